// File: rtl/bus_width_conv_arbiter_pkg.sv
// Shared definitions for the wide-to-narrow converter arbiter: FSM encodings
// and the wide-word width helper.
package bus_decode_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   function automatic int calc_high_width(input int low_width, input int brust_size_log);
      return low_width * (2 ** brust_size_log);
   endfunction

endpackage

// File: rtl/bus_width_conv_arbiter_if.sv
// Requester and converter-side signals of the arbiter; slave is the arbiter's
// view, master is the view of the requesters and converter driving it.
interface bus_width_conv_arbiter_if
   import bus_decode_pkg::*;
#(
   parameter int LOW_DATA_WIDTH = 32,
   parameter int BRUST_SIZE_LOG = 2,
   parameter int REQ_NUM_LOG    = 2
);
   localparam int REQ_NUM    = 2 ** REQ_NUM_LOG;
   localparam int HIGH_WIDTH = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG);

   logic [REQ_NUM-1:0]            req_valid;
   logic [REQ_NUM*HIGH_WIDTH-1:0] req_data;
   logic [REQ_NUM-1:0]            req_mask;
   logic [REQ_NUM-1:0]            req_finish;
   logic [HIGH_WIDTH-1:0]         conv_read_data;
   logic                          conv_read_valid;
   logic                          conv_read_finish;
   logic [REQ_NUM_LOG-1:0]        grant_id;
   logic                          busy;

   modport slave (
      input  req_valid, req_data, req_mask, conv_read_finish,
      output req_finish, conv_read_data, conv_read_valid, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_mask, conv_read_finish,
      input  req_finish, conv_read_data, conv_read_valid, grant_id, busy
   );

endinterface

// File: rtl/bus_width_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i,
// wrapping modulo the requester count.
module rr_pick
   import bus_decode_pkg::*;
#(
   parameter int REQ_NUM_LOG = 2
) (
   input  logic [2**REQ_NUM_LOG-1:0] eligible_i,
   input  logic [REQ_NUM_LOG-1:0]    rr_ptr_i,
   output logic [REQ_NUM_LOG-1:0]    winner_o,
   output logic                      any_eligible_o
);
   localparam int REQ_NUM = 2 ** REQ_NUM_LOG;

   logic [REQ_NUM_LOG-1:0] idx;
   logic                   found;

   always_comb begin
      winner_o = '0;
      idx      = '0;
      found    = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = rr_ptr_i + REQ_NUM_LOG'(k);
         if (!found && eligible_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
      end
   end

   assign any_eligible_o = |eligible_i;

endmodule

// File: rtl/bus_width_conv_arbiter.sv
// Round-robin sharing of one wide-to-narrow converter between REQ_NUM wide
// requesters: latch the winner's word, pulse it to the converter, relay finish.
//
// state   | meaning
// IDLE    | waiting for an enabled, valid requester
// ISSUE   | conv_read_valid high for exactly one cycle
// WAIT    | word held, waiting for conv_read_finish
// RELEASE | req_finish pulse to the granted requester
module bus_width_conv_arbiter
   import bus_decode_pkg::*;
#(
   parameter int LOW_DATA_WIDTH = 32,
   parameter int BRUST_SIZE_LOG = 2,
   parameter int REQ_NUM_LOG    = 2
) (
   input logic                    clk,
   input logic                    rst,
   bus_width_conv_arbiter_if.slave bus
);
   localparam int REQ_NUM    = 2 ** REQ_NUM_LOG;
   localparam int HIGH_WIDTH = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG);

   logic [1:0]             state_q, state_d;
   logic [REQ_NUM_LOG-1:0] rr_ptr_q, rr_ptr_d;
   logic [REQ_NUM_LOG-1:0] grant_q, grant_d;
   logic [HIGH_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic [REQ_NUM-1:0]     finish_q, finish_d;
   logic                   busy_q;

   logic [REQ_NUM-1:0]     eligible;
   logic [REQ_NUM_LOG-1:0] winner;
   logic                   any_eligible;

   assign eligible = bus.req_valid & bus.req_mask;

   rr_pick #(.REQ_NUM_LOG(REQ_NUM_LOG)) u_rr_pick (
      .eligible_i     (eligible),
      .rr_ptr_i       (rr_ptr_q),
      .winner_o       (winner),
      .any_eligible_o (any_eligible)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      finish_d = '0;
      case (state_q)
         IDLE: begin
            if (any_eligible) begin
               grant_d = winner;
               data_d  = bus.req_data[winner*HIGH_WIDTH +: HIGH_WIDTH];
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (bus.conv_read_finish) begin
               finish_d[grant_q] = 1'b1;
               // pointer moves past the winner only on completion
               rr_ptr_d          = grant_q + 1'b1;
               state_d           = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         finish_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         finish_q <= finish_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign bus.req_finish      = finish_q;
   assign bus.conv_read_data  = data_q;
   assign bus.conv_read_valid = valid_q;
   assign bus.grant_id        = grant_q;
   assign bus.busy            = busy_q;

endmodule

// File: doc/bus_width_conv_arbiter.md
Name: bus_width_conv_arbiter

Overview:
Shares one wide-to-narrow width converter (high_to_low) between REQ_NUM wide-bus requesters. Round-robin arbitration picks one requester and latches its wide word. The block issues that word to the converter with a one-cycle valid pulse, waits for the converter's finish pulse, then returns a finish pulse to the granted requester. It sits between the wide-side masters and the converter's high_read_* port.

Parameters:
LOW_DATA_WIDTH, 32, narrow-bus word width; must match the converter.
BRUST_SIZE_LOG, 2, log2 of narrow beats per wide word; must match the converter.
REQ_NUM_LOG, 2, log2 of requester count; REQ_NUM = 2**REQ_NUM_LOG (derived, not overridable).
HIGH_WIDTH, derived = LOW_DATA_WIDTH * 2**BRUST_SIZE_LOG.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  REQ_NUM  per-requester request; held high until that requester's req_finish
req_data  in  REQ_NUM*HIGH_WIDTH  requester i word at [i*HIGH_WIDTH +: HIGH_WIDTH]
req_mask  in  REQ_NUM  1 = requester enabled; sampled only in IDLE
req_finish  out  REQ_NUM  one-hot, one-cycle pulse: transfer for requester i is complete
conv_read_data  out  HIGH_WIDTH  word to converter high_read_data; held stable from ISSUE through WAIT
conv_read_valid  out  1  one-cycle pulse to converter high_read_valid
conv_read_finish  in  1  converter high_read_finish pulse
grant_id  out  REQ_NUM_LOG  index of current or last granted requester
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0; grant_id=0; conv_read_data=0; conv_read_valid=0; req_finish=0; busy=0.
- Reset mid-operation aborts the transfer silently. No req_finish is issued. The converter must share the same reset event.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: eligible = req_valid & req_mask. If eligible != 0, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo REQ_NUM. On that edge: grant_id <= winner; conv_read_data <= req_data slice of winner; conv_read_valid <= 1; go to ISSUE.
  - ISSUE: lasts exactly one cycle with conv_read_valid=1. Next edge: conv_read_valid <= 0; go to WAIT.
  - WAIT: hold conv_read_data. When conv_read_finish=1: req_finish[grant_id] <= 1; rr_ptr <= grant_id+1 (wraps naturally at REQ_NUM); go to RELEASE.
  - RELEASE: one cycle with req_finish pulse high. Next edge: req_finish <= 0; go to IDLE.
- Latency: eligible request in IDLE at cycle T -> conv_read_valid high at T+1. conv_read_finish at cycle F -> req_finish high at F+1 -> IDLE at F+2. Minimum back-to-back grant gap: next conv_read_valid at F+3.
- conv_read_valid is a pulse, never a level, so the converter cannot restart on a stale valid.
- conv_read_finish in IDLE, ISSUE or RELEASE is ignored.
- Requests, mask changes and req_data changes outside IDLE have no effect on the current transfer; the data is already latched.
- Requester contract: drop req_valid on the edge that samples req_finish=1. The rotated pointer guarantees fairness even if a requester re-requests immediately.
- Fairness: rr_ptr rotates only on completion. A masked or idle requester is skipped with no bubble cycle.
- req_mask=0 in IDLE: the block stays in IDLE regardless of req_valid.

Decomposition:
- Shared package bus_decode_pkg holds:
  - FSM state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RELEASE=2'd3.
  - Helper function computing HIGH_WIDTH from LOW_DATA_WIDTH and BRUST_SIZE_LOG.
- One sub-module rr_pick, purely combinational.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: winner index and any_eligible.
  - The FSM, data latch and pointer register stay in the top module.

Test Plan:
1. Single request: rst pulse; req_mask=4'hF; req_valid=4'b0100, req_data slice2=128'hDDDD_CCCC_BBBB_AAAA; model finish 5 cycles after valid -> grant_id=2; conv_read_valid one cycle at T+1 with that data; req_finish=4'b0100 exactly one cycle after conv_read_finish; rr_ptr=3.
2. Round-robin: all four requesters held high, each dropping on its own finish -> grant order 0,1,2,3. With requester 0 re-requesting immediately after its finish, the order continues 1,2,3,0 with no starvation.
3. Mask: req_valid=4'b1111, req_mask=4'b1010 -> grants alternate 1,3,1,3; requesters 0 and 2 never receive req_finish.
4. Converter integration: instance of high_to_low with reset tied to ~rst; word 128'h0000_0004_0000_0003_0000_0002_0000_0001 -> converter emits narrow beats 1,2,3,4, then req_finish pulses once; conv_read_valid is never high for more than one cycle.
5. Spurious and late inputs: conv_read_finish pulsed in IDLE and ISSUE -> ignored, no req_finish. req_data of the granted requester changed during WAIT -> conv_read_data unchanged.
6. Reset mid-transfer: rst asserted in WAIT -> all outputs 0 asynchronously, rr_ptr=0, no req_finish. After release with req_valid=4'b0001 -> normal grant to 0.
